// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and FSM encoding for the two-channel FIR MAC scheduler.
package fir_pkg;

   localparam int NTAPS = 22;
   localparam int DW    = 8;
   localparam int ACCW  = 20;
   localparam int NCOEF = 11;

   // Half of the symmetric impulse response; C_TAB[0] is the outermost tap.
   localparam logic [NCOEF-1:0][7:0] C_TAB = {
      8'd128, 8'd122, 8'd111, 8'd95, 8'd78, 8'd60,
      8'd43,  8'd28,  8'd16,  8'd10, 8'd2
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample-in / result-out bundle between the two LED sample sources and the FIR MAC scheduler.
interface fir_mac_scheduler_if #(
   parameter int DW   = fir_pkg::DW,
   parameter int ACCW = fir_pkg::ACCW
) ();
   import fir_pkg::*;

   // A sample transfers on a rising edge where valid && ready; the source holds
   // valid and sample stable until then. out_valid is a one-cycle pulse with no
   // backpressure, and out_data/out_chan hold until the next result.
   logic            red_valid;
   logic [DW-1:0]   red_sample;
   logic            red_ready;
   logic            ir_valid;
   logic [DW-1:0]   ir_sample;
   logic            ir_ready;
   logic            out_valid;
   logic            out_chan;
   logic [ACCW-1:0] out_data;
   logic            busy;
   fsm_state_t      state_dbg;

   modport master (
      output red_valid, red_sample, ir_valid, ir_sample,
      input  red_ready, ir_ready, out_valid, out_chan, out_data, busy, state_dbg
   );

   modport slave (
      input  red_valid, red_sample, ir_valid, ir_sample,
      output red_ready, ir_ready, out_valid, out_chan, out_data, busy, state_dbg
   );

endinterface

// File: rtl/fir_coef_rom.sv
// Combinational 22-tap symmetric coefficient lookup; taps past 21 read as zero.
module fir_coef_rom
   import fir_pkg::*;
(
   input  logic [4:0] k,
   output logic [7:0] coef
);

   logic [3:0] fold;

   always_comb begin
      fold = (k <= 5'd10) ? k[3:0] : 4'(5'd21 - k);
      coef = (k <= 5'd21) ? C_TAB[fold] : 8'd0;
   end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Two-channel FIR filter sharing one multiplier and accumulator; round-robin
// between red and IR samples, one result every NTAPS+2 cycles.
module fir_mac_scheduler #(
   parameter int NTAPS = fir_pkg::NTAPS,
   parameter int DW    = fir_pkg::DW,
   parameter int ACCW  = fir_pkg::ACCW
) (
   input logic               CLK_Filter,
   input logic               rst_n,
   fir_mac_scheduler_if.slave bus
);
   import fir_pkg::*;

   localparam int PW = $clog2(NTAPS);

   fsm_state_t      state;
   logic [DW-1:0]   red_buf [NTAPS];
   logic [DW-1:0]   ir_buf  [NTAPS];
   logic [PW-1:0]   red_wr, ir_wr, head, k, tap_idx;
   logic            chan, last_ir;
   logic [ACCW-1:0] acc;
   logic            out_valid, out_chan;
   logic [ACCW-1:0] out_data;
   logic            red_rdy, ir_rdy;
   logic [7:0]      coef;
   logic [DW-1:0]   tap_sample;
   logic [DW+7:0]   product;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(NTAPS - 1)) ? '0 : p + 1'b1;
   endfunction

   // Red wins a tie unless it was the channel served last.
   always_comb begin
      red_rdy = rst_n && (state == IDLE) && bus.red_valid && (!bus.ir_valid || last_ir);
      ir_rdy  = rst_n && (state == IDLE) && bus.ir_valid && (!bus.red_valid || !last_ir);
   end

   // Newest sample sits at head; tap k reaches back k samples, wrapping the ring.
   always_comb begin
      tap_idx    = (head >= k) ? head - k : head + PW'(NTAPS) - k;
      tap_sample = chan ? ir_buf[tap_idx] : red_buf[tap_idx];
      product    = coef * tap_sample;
   end

   fir_coef_rom u_coef_rom (
      .k    (5'(k)),
      .coef (coef)
   );

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         for (int i = 0; i < NTAPS; i++) begin
            red_buf[i] <= '0;
            ir_buf[i]  <= '0;
         end
         red_wr    <= '0;
         ir_wr     <= '0;
         head      <= '0;
         k         <= '0;
         chan      <= 1'b0;
         last_ir   <= 1'b1;
         acc       <= '0;
         out_valid <= 1'b0;
         out_chan  <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (red_rdy) begin
                  red_buf[red_wr] <= bus.red_sample;
                  head    <= red_wr;
                  red_wr  <= next_ptr(red_wr);
                  chan    <= 1'b0;
                  last_ir <= 1'b0;
                  acc     <= '0;
                  k       <= '0;
                  state   <= MAC;
               end else if (ir_rdy) begin
                  ir_buf[ir_wr] <= bus.ir_sample;
                  head    <= ir_wr;
                  ir_wr   <= next_ptr(ir_wr);
                  chan    <= 1'b1;
                  last_ir <= 1'b1;
                  acc     <= '0;
                  k       <= '0;
                  state   <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACCW'(product);
               k   <= k + 1'b1;
               if (k == PW'(NTAPS - 1)) state <= DONE;
            end
            DONE: begin
               out_data  <= acc;
               out_chan  <= chan;
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.red_ready = red_rdy;
   assign bus.ir_ready  = ir_rdy;
   assign bus.out_valid = out_valid;
   assign bus.out_chan  = out_chan;
   assign bus.out_data  = out_data;
   assign bus.busy      = (state != IDLE);
   assign bus.state_dbg = state;

endmodule
